// File: rtl/axis_frame_buffer.sv
// Store-and-forward AXI-Stream frame buffer: a frame is released only after its last beat is stored.
// Optional `AXIS_FB_STATS_EN adds frames_in / frames_out commit and release counters.
module axis_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tvalid,
  output logic              tready,
  input  logic              tlast,
  input  logic [DATA_W-1:0] tdata,
  output logic              ovalid,
  input  logic              oready,
  output logic              olast,
  output logic [DATA_W-1:0] odata,
  output logic              oversize
`ifdef AXIS_FB_STATS_EN
  ,
  output logic [15:0]       frames_in,
  output logic [15:0]       frames_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] ZERO = '0;

  logic [DATA_W:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_used;
  logic [AW:0]     r_frames;
  logic            r_oversize;

  logic            w_push;
  logic            w_pop;
  logic            w_split;
  logic            w_commit;
  logic            w_rd_last;
  logic [DATA_W:0] w_rd_entry;

  // Handshakes: a beat moves on a side exactly in a cycle where valid && ready at the clock edge;
  // valid never waits on ready, and tready depends only on registered occupancy.
  assign tready     = (r_used != FULL);
  assign ovalid     = (r_frames != ZERO);
  assign w_rd_entry = r_mem[r_rd_ptr];
  assign w_rd_last  = w_rd_entry[DATA_W];
  assign olast      = ovalid ? w_rd_last : 1'b0;
  assign odata      = ovalid ? w_rd_entry[DATA_W-1:0] : '0;
  assign oversize   = r_oversize;

  assign w_push   = reset && tvalid && tready;
  assign w_pop    = reset && ovalid && oready;
  // No committed frame means no release this cycle, so this beat is the one that fills the buffer.
  assign w_split  = w_push && !tlast && (r_frames == ZERO) && (r_used == FULL - ONE);
  assign w_commit = w_push && (tlast || w_split);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {tlast | w_split, tdata};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_used     <= '0;
      r_frames   <= '0;
      r_oversize <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_used   <= r_used + (w_push ? ONE : ZERO) - (w_pop ? ONE : ZERO);
      r_frames <= r_frames + (w_commit ? ONE : ZERO) - ((w_pop && w_rd_last) ? ONE : ZERO);
      if (w_split) r_oversize <= 1'b1;
    end
  end

`ifdef AXIS_FB_STATS_EN
  logic [15:0] r_frames_in;
  logic [15:0] r_frames_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frames_in  <= '0;
      r_frames_out <= '0;
    end else begin
      if (w_commit)             r_frames_in  <= r_frames_in + 16'd1;
      if (w_pop && w_rd_last)   r_frames_out <= r_frames_out + 16'd1;
    end
  end

  assign frames_in  = r_frames_in;
  assign frames_out = r_frames_out;
`endif

endmodule
